// File: rtl/axi_read_arbiter.sv
// ----------------------------------------------------------------------------
// axi_read_arbiter
//
// Shares one AXI4 read channel (AR + R) between two requesters:
//   req 0 : ICache refill / uncached fetch
//   req 1 : DCache refill
// One burst is in flight at a time. Ties go to the requester named by a
// round-robin priority bit. The AR fields are captured into registers when the
// request is accepted, and R beats are steered back to the owner until the
// r_last handshake.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   s_ar_valid/ready[1:0]       per-requester request / capture pulse
//   s_ar_addr/len/size[1:0]     per-requester burst description
//   s_r_valid[1:0], s_r_ready   per-requester beat handshake
//   s_r_data/last/resp          shared R payload, qualified by s_r_valid
//   m_ar_*                      AXI AR master side (registered fields)
//   m_r_*                       AXI R master side
// ----------------------------------------------------------------------------
module axi_read_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    // requester AR side
    input  logic [1:0]             s_ar_valid,
    output logic [1:0]             s_ar_ready,
    input  logic [1:0][ADDR_W-1:0] s_ar_addr,
    input  logic [1:0][LEN_W-1:0]  s_ar_len,
    input  logic [1:0][2:0]        s_ar_size,
    // requester R side
    output logic [1:0]             s_r_valid,
    input  logic [1:0]             s_r_ready,
    output logic [DATA_W-1:0]      s_r_data,
    output logic                   s_r_last,
    output logic [1:0]             s_r_resp,
    // AXI AR
    output logic                   m_ar_valid,
    input  logic                   m_ar_ready,
    output logic [ADDR_W-1:0]      m_ar_addr,
    output logic [LEN_W-1:0]       m_ar_len,
    output logic [2:0]             m_ar_size,
    output logic [ID_W-1:0]        m_ar_id,
    output logic [1:0]             m_ar_burst,
    // AXI R
    input  logic                   m_r_valid,
    output logic                   m_r_ready,
    input  logic [DATA_W-1:0]      m_r_data,
    input  logic                   m_r_last,
    input  logic [1:0]             m_r_resp
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              prio_q, prio_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [2:0]        size_q, size_d;

    logic              win;
    logic              grant;
    logic              owner_ready;

    // Winner: a lone valid requester always wins; with both valid the
    // priority bit decides. Only meaningful while some request is valid.
    assign win = s_ar_valid[1] & (~s_ar_valid[0] | prio_q);

    // The owner's ready is the only R backpressure; nothing is buffered here.
    assign owner_ready = s_r_ready[owner_q];

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        prio_d     = prio_q;
        addr_d     = addr_q;
        len_d      = len_q;
        size_d     = size_q;
        grant      = 1'b0;
        m_ar_valid = 1'b0;
        m_r_ready  = 1'b0;

        case (state_q)
            IDLE: begin
                if (|s_ar_valid) begin
                    grant   = 1'b1;
                    owner_d = win;
                    addr_d  = s_ar_addr[win];
                    len_d   = s_ar_len[win];
                    size_d  = s_ar_size[win];
                    state_d = ADDR;
                end
            end
            ADDR: begin
                m_ar_valid = 1'b1;
                if (m_ar_ready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                m_r_ready = owner_ready;
                // Completion depends only on the last-beat handshake; beats
                // are not counted and the response code is not inspected.
                if (m_r_valid && owner_ready && m_r_last) begin
                    state_d = IDLE;
                    prio_d  = ~owner_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Per-requester handshake steering. s_ar_ready is gated with rst_n so the
    // combinational grant path stays quiet while reset is held.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign s_ar_ready[gi] = rst_n & grant & (win == 1'(gi));
            assign s_r_valid[gi]  = (state_q == DATA) & (owner_q == 1'(gi)) & m_r_valid;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
        end
    end

    assign m_ar_addr  = addr_q;
    assign m_ar_len   = len_q;
    assign m_ar_size  = size_q;
    assign m_ar_id    = ID_W'(owner_q);
    assign m_ar_burst = 2'b01;

    assign s_r_data   = m_r_data;
    assign s_r_last   = m_r_last;
    assign s_r_resp   = m_r_resp;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// ----------------------------------------------------------------------------
// tb_axi_read_arbiter
//
// Directed bench for axi_read_arbiter. A table of burst records (request mask,
// per-requester AR fields, AR wait, R stall, response code, expected winner)
// is run in order; each record drives one full burst from request to r_last.
// Hand-written sequences cover reset mid-burst and the no-phantom-grant case.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// ----------------------------------------------------------------------------
module tb_axi_read_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;
    localparam int LEN_W  = 8;

    logic                   clk;
    logic                   rst_n;
    logic [1:0]             s_ar_valid;
    logic [1:0]             s_ar_ready;
    logic [1:0][ADDR_W-1:0] s_ar_addr;
    logic [1:0][LEN_W-1:0]  s_ar_len;
    logic [1:0][2:0]        s_ar_size;
    logic [1:0]             s_r_valid;
    logic [1:0]             s_r_ready;
    logic [DATA_W-1:0]      s_r_data;
    logic                   s_r_last;
    logic [1:0]             s_r_resp;
    logic                   m_ar_valid;
    logic                   m_ar_ready;
    logic [ADDR_W-1:0]      m_ar_addr;
    logic [LEN_W-1:0]       m_ar_len;
    logic [2:0]             m_ar_size;
    logic [ID_W-1:0]        m_ar_id;
    logic [1:0]             m_ar_burst;
    logic                   m_r_valid;
    logic                   m_r_ready;
    logic [DATA_W-1:0]      m_r_data;
    logic                   m_r_last;
    logic [1:0]             m_r_resp;

    axi_read_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
        .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len), .s_ar_size(s_ar_size),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
        .s_r_data(s_r_data), .s_r_last(s_r_last), .s_r_resp(s_r_resp),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
        .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_size(m_ar_size),
        .m_ar_id(m_ar_id), .m_ar_burst(m_ar_burst),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
        .m_r_data(m_r_data), .m_r_last(m_r_last), .m_r_resp(m_r_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic              do_rst;   // pulse reset before this burst
        logic [1:0]        mask;     // requests driven in the first IDLE cycle
        logic [ADDR_W-1:0] addr0;
        logic [ADDR_W-1:0] addr1;
        logic [LEN_W-1:0]  len0;
        logic [LEN_W-1:0]  len1;
        logic [2:0]        size0;
        logic [2:0]        size1;
        int                ar_wait;  // ADDR cycles before m_ar_ready rises
        int                stall;    // cycles the owner withholds ready at beat 1
        logic [1:0]        resp;
        logic              exp_win;
    } burst_t;

    burst_t tbl[7];

    // Entered and left 1 time unit after a rising edge, with the DUT in IDLE.
    task automatic run_burst(input burst_t b);
        logic              w;
        logic [ADDR_W-1:0] a;
        logic [LEN_W-1:0]  l;
        logic [2:0]        sz;
        int                cnt;
        int                k;
        int                st;
        logic              rdy;
        w  = b.exp_win;
        a  = w ? b.addr1 : b.addr0;
        l  = w ? b.len1  : b.len0;
        sz = w ? b.size1 : b.size0;

        s_ar_valid   = b.mask;
        s_ar_addr[0] = b.addr0;
        s_ar_addr[1] = b.addr1;
        s_ar_len[0]  = b.len0;
        s_ar_len[1]  = b.len1;
        s_ar_size[0] = b.size0;
        s_ar_size[1] = b.size1;

        // Request cycle: grant pulse must appear in the same cycle.
        cnt = 0;
        @(negedge clk);
        while (s_ar_ready == 2'b00 && cnt < 20) begin
            @(posedge clk); #1;
            @(negedge clk);
            cnt++;
        end
        chk("grant", {62'd0, s_ar_ready}, {62'd0, (2'b01 << w)});
        chk("grant_latency", 64'(cnt), 64'd0);
        chk("ar_valid_in_idle", {63'd0, m_ar_valid}, 64'd0);
        @(posedge clk); #1;
        s_ar_valid[w] = 1'b0;   // owner withdraws after capture (flush)

        // ADDR phase; stray R valid/last here must be ignored.
        m_r_valid = 1'b1;
        m_r_last  = 1'b1;
        for (int c = 0; c <= b.ar_wait; c++) begin
            m_ar_ready = (c == b.ar_wait);
            @(negedge clk);
            chk("ar_valid", {63'd0, m_ar_valid}, 64'd1);
            chk("ar_addr", 64'(m_ar_addr), 64'(a));
            chk("ar_len", 64'(m_ar_len), 64'(l));
            chk("ar_size", 64'(m_ar_size), 64'(sz));
            chk("ar_id", 64'(m_ar_id), 64'(w));
            chk("ar_burst", 64'(m_ar_burst), 64'd1);
            chk("ar_ready_hold", {62'd0, s_ar_ready}, 64'd0);
            chk("r_ready_in_addr", {63'd0, m_r_ready}, 64'd0);
            chk("r_valid_in_addr", {62'd0, s_r_valid}, 64'd0);
            @(posedge clk); #1;
        end
        m_ar_ready = 1'b0;

        // DATA phase.
        k  = 0;
        st = 0;
        m_r_valid = 1'b1;
        while (k <= int'(l)) begin
            m_r_data     = a + 32'(4 * k);
            m_r_last     = (k == int'(l));
            m_r_resp     = b.resp;
            rdy          = !(k == 1 && st < b.stall);
            s_r_ready[w]  = rdy;
            s_r_ready[!w] = !rdy;
            @(negedge clk);
            chk("r_valid_steer", {62'd0, s_r_valid}, {62'd0, (2'b01 << w)});
            chk("r_data", 64'(s_r_data), 64'(a + 32'(4 * k)));
            chk("r_last", {63'd0, s_r_last}, {63'd0, (k == int'(l))});
            chk("r_resp", 64'(s_r_resp), 64'(b.resp));
            chk("m_r_ready", {63'd0, m_r_ready}, {63'd0, rdy});
            chk("ar_ready_in_data", {62'd0, s_ar_ready}, 64'd0);
            chk("ar_valid_in_data", {63'd0, m_ar_valid}, 64'd0);
            if (rdy) k++;
            else     st++;
            @(posedge clk); #1;
        end
        m_r_valid = 1'b0;
        m_r_last  = 1'b0;
        s_r_ready = 2'b00;
        $display("burst: owner=%0d addr=%08h len=%0d ar_wait=%0d stall=%0d", w, a, l, b.ar_wait, b.stall);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //        rst   mask   addr0          addr1          l0  l1  s0  s1  aw st resp  win
        tbl[0] = '{1'b0, 2'b01, 32'h1C00_0040, 32'h0,         3, 0, 2, 2, 1, 0, 2'b00, 1'b0};
        tbl[1] = '{1'b1, 2'b11, 32'h0000_1000, 32'h8000_2000, 1, 2, 2, 3, 0, 0, 2'b00, 1'b0};
        tbl[2] = '{1'b0, 2'b11, 32'h0000_1100, 32'h8000_2000, 1, 2, 2, 3, 0, 0, 2'b00, 1'b1};
        tbl[3] = '{1'b0, 2'b11, 32'h0000_1200, 32'h8000_2400, 2, 1, 1, 2, 0, 0, 2'b01, 1'b0};
        tbl[4] = '{1'b0, 2'b01, 32'h0000_3000, 32'h0,         2, 0, 2, 0, 5, 0, 2'b00, 1'b0};
        tbl[5] = '{1'b0, 2'b10, 32'h0,         32'h8000_4000, 0, 4, 0, 2, 0, 3, 2'b10, 1'b1};
        tbl[6] = '{1'b0, 2'b11, 32'h0000_5000, 32'h8000_6000, 0, 0, 2, 2, 0, 0, 2'b00, 1'b0};

        rst_n      = 1'b0;
        s_ar_valid = 2'b00;
        s_ar_addr  = '0;
        s_ar_len   = '0;
        s_ar_size  = '0;
        s_r_ready  = 2'b00;
        m_ar_ready = 1'b0;
        m_r_valid  = 1'b0;
        m_r_data   = '0;
        m_r_last   = 1'b0;
        m_r_resp   = 2'b00;

        // Reset state.
        @(negedge clk);
        chk("rst_ar_valid", {63'd0, m_ar_valid}, 64'd0);
        chk("rst_ar_addr", 64'(m_ar_addr), 64'd0);
        chk("rst_ar_len", 64'(m_ar_len), 64'd0);
        chk("rst_ar_id", 64'(m_ar_id), 64'd0);
        chk("rst_r_ready", {63'd0, m_r_ready}, 64'd0);
        chk("rst_ar_ready", {62'd0, s_ar_ready}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].do_rst) begin
                rst_n = 1'b0;
                #2;
                chk("rst_pulse_ar_valid", {63'd0, m_ar_valid}, 64'd0);
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
            run_burst(tbl[i]);
        end
        // Last table burst was owned by req 0, so priority now favours req 1.

        // Reset mid-burst: get req 1 into DATA, then pull rst_n low.
        s_ar_valid   = 2'b10;
        s_ar_addr[1] = 32'h8000_7000;
        s_ar_len[1]  = 8'd3;
        @(posedge clk); #1;
        s_ar_valid = 2'b00;
        m_ar_ready = 1'b1;
        @(posedge clk); #1;
        m_ar_ready = 1'b0;
        m_r_valid  = 1'b1;
        m_r_data   = 32'hDEAD_0001;
        s_r_ready  = 2'b10;
        @(negedge clk);
        chk("pre_rst_in_data", {62'd0, s_r_valid}, 64'd2);
        #1;
        rst_n      = 1'b0;
        s_ar_valid = 2'b11;
        #1;
        chk("async_rst_r_valid", {62'd0, s_r_valid}, 64'd0);
        chk("async_rst_r_ready", {63'd0, m_r_ready}, 64'd0);
        chk("async_rst_ar_valid", {63'd0, m_ar_valid}, 64'd0);
        chk("async_rst_ar_ready", {62'd0, s_ar_ready}, 64'd0);
        chk("async_rst_ar_addr", 64'(m_ar_addr), 64'd0);
        m_r_valid  = 1'b0;
        s_ar_valid = 2'b00;
        s_r_ready  = 2'b00;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // No phantom grant while nothing is requesting.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("phantom_ar_ready", {62'd0, s_ar_ready}, 64'd0);
            chk("phantom_ar_valid", {63'd0, m_ar_valid}, 64'd0);
            @(posedge clk); #1;
        end

        // Priority was reset to 0: a tie goes to req 0.
        run_burst('{1'b0, 2'b11, 32'h0000_9000, 32'h8000_9000, 1, 1, 2, 2, 0, 0, 2'b00, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
